fpu_rt_wb_arb: RTL
==================

Name: fpu_rt_wb_arb

Overview:
- Writeback arbiter directly downstream of the iterative sqrt/div engine bank (N_ENG rt2-style engines).
- Collects finished results, grants one engine per cycle round-robin, and drives the FPU alt writeback port.
- Tag fields (outEn, outII, outOp, FUreg, FUwen) go out one cycle after the grant; result data goes out DATA_DLY cycles after the tag, lined up with the register-file alt write slot.

Parameters:
N_ENG, 4, number of engines arbitrated
DATA_W, 136, result width (2x68 SIMD half)
REG_W, 9, destination register number width
II_W, 10, instruction index width
OP_W, 13, opcode width
DATA_DLY, 5, cycles from tag valid to outAltData valid (1..8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
eng_done  in  N_ENG  engine n holds a finished result
eng_res  in  N_ENG*DATA_W  per-engine result, stable while eng_done[n]
eng_reg  in  N_ENG*REG_W  per-engine destination register
eng_ii  in  N_ENG*II_W  per-engine instruction index
eng_op  in  N_ENG*OP_W  per-engine opcode
wb_block  in  1  alt writeback slot taken by another unit this cycle
eng_ack  out  N_ENG  one-hot grant; engine drops eng_done next cycle
outEn  out  4  4'b1001 when a tag is valid, else 0
outII  out  II_W  tag instruction index
outOp  out  OP_W  tag opcode
FUreg  out  REG_W  tag destination register
FUwen  out  1  register write enable
outAltData  out  DATA_W  delayed result data, 0 when not valid
busy  out  1  any eng_done high or any data stage valid

Behaviour:
- Reset: rr_ptr=0, every output 0, all data pipe valid bits cleared. Takes effect in the cycle rst is sampled high.
- Grant (combinational, cycle T):
  - Scan eng_done starting at rr_ptr, wrapping modulo N_ENG; the first set bit wins.
  - eng_ack is that one-hot bit if wb_block=0 and rst=0, otherwise 0.
  - At most one ack per cycle.
- rr_ptr update: on a grant to engine g, rr_ptr <= (g+1) mod N_ENG. Otherwise unchanged.
- Tag stage (registered, cycle T+1):
  - outEn=4'b1001, FUwen=1, and outII/outOp/FUreg from engine g as sampled at T.
  - With no grant at T: outEn=0, FUwen=0, outII/outOp/FUreg=0.
- Data pipe:
  - DATA_DLY-stage shift register of {valid, data}.
  - Stage 1 loads eng_res[g] at the grant edge; each stage advances every cycle with no stall.
  - outAltData = last stage data if its valid=1, else 0. For a grant at T, data appears at T+1+DATA_DLY.
- Engines hold eng_done and their payload until acked. The arbiter never drops or duplicates a result.
- wb_block=1 in a cycle: no ack, rr_ptr held, tag outputs 0 next cycle. The data pipe still shifts.
- Simultaneous done, e.g. all four: served in rr order over consecutive cycles, one per cycle.
- Back-to-back grants produce back-to-back tags and back-to-back data beats.
- eng_done[n] falling without an ack: the arbiter ignores it (engine error; an assertion in the bench flags it).
- Reset mid-operation: pending data pipe contents are discarded and no further output is produced. Engines are reset by the same rst.
- Widths: index arithmetic uses $clog2(N_ENG) bits; N_ENG must be a power of two.

Decomposition:
- Shared FPU package: ALT_OUTEN constant 4'b1001 and the REG_W/II_W/OP_W widths.
- Sub-module rt_rr_pick: combinational round-robin picker; inputs req and ptr, outputs one-hot grant and valid.
- Data pipe stays inline.

Test Plan:
- Single done: eng_done=4'b0100 at T, wb_block=0 → eng_ack=4'b0100 at T; outEn=4'b1001 with engine 2 tag at T+1; outAltData=eng_res[2] at T+6, 0 at T+5 and T+7.
- All four done at T, rr_ptr=0 → acks 0,1,2,3 in T..T+3; four consecutive tags from T+1; data beats T+6..T+9 in the same order.
- Fairness: engines 0 and 1 re-assert done immediately after each ack for 20 cycles → grants alternate 0,1,0,1,…; neither starves.
- wb_block high T..T+2 with eng_done=4'b1000 → no ack until T+3; tag at T+4; data at T+9; rr_ptr unchanged during the block.
- Reset mid-flight: grant at T, rst at T+2 → outEn=0 from T+3; outAltData stays 0 through T+10.
- DATA_DLY=1 build: single grant at T → data at T+2, matching the tag-to-data delay.

Source files
------------

// File: rtl/fpu_rt_wb_arb_pkg.sv
// Shared FPU constants for the alt writeback path: tag enable pattern and field widths.
package fpu_rt_wb_arb_pkg;

    localparam logic [3:0] ALT_OUTEN = 4'b1001;
    localparam int FPU_REG_W = 9;
    localparam int FPU_II_W  = 10;
    localparam int FPU_OP_W  = 13;

endpackage

// File: rtl/fpu_rt_wb_arb_rt_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// with the search wrapping modulo N.
module rt_rr_pick
    import fpu_rt_wb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // idx wraps naturally in PW bits because N is a power of two
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/fpu_rt_wb_arb.sv
// Alt writeback arbiter for the sqrt/div engine bank: round-robin grant, tag one
// cycle after the grant, result data DATA_DLY cycles after the tag.
module fpu_rt_wb_arb
    import fpu_rt_wb_arb_pkg::*;
#(
    parameter int N_ENG    = 4,
    parameter int DATA_W   = 136,
    parameter int REG_W    = FPU_REG_W,
    parameter int II_W     = FPU_II_W,
    parameter int OP_W     = FPU_OP_W,
    parameter int DATA_DLY = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_ENG-1:0]        eng_done,
    input  logic [N_ENG*DATA_W-1:0] eng_res,
    input  logic [N_ENG*REG_W-1:0]  eng_reg,
    input  logic [N_ENG*II_W-1:0]   eng_ii,
    input  logic [N_ENG*OP_W-1:0]   eng_op,
    input  logic                    wb_block,
    output logic [N_ENG-1:0]        eng_ack,
    output logic [3:0]              outEn,
    output logic [II_W-1:0]         outII,
    output logic [OP_W-1:0]         outOp,
    output logic [REG_W-1:0]        FUreg,
    output logic                    FUwen,
    output logic [DATA_W-1:0]       outAltData,
    output logic                    busy
);

    localparam int PW = $clog2(N_ENG);

    logic [N_ENG-1:0]  pick_grant;
    logic              pick_valid;
    logic              do_grant;

    logic [DATA_W-1:0] sel_res;
    logic [REG_W-1:0]  sel_reg;
    logic [II_W-1:0]   sel_ii;
    logic [OP_W-1:0]   sel_op;
    logic [PW-1:0]     sel_idx;

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]        out_en_q, out_en_d;
    logic [II_W-1:0]   out_ii_q, out_ii_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [REG_W-1:0]  fu_reg_q, fu_reg_d;
    logic              fu_wen_q, fu_wen_d;

    logic [DATA_DLY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0]   pipe_dat_q [DATA_DLY];
    logic [DATA_W-1:0]   pipe_dat_d [DATA_DLY];
    logic                alt_vld_q, alt_vld_d;
    logic [DATA_W-1:0]   alt_data_q, alt_data_d;

    rt_rr_pick #(.N(N_ENG)) u_pick (
        .req   (eng_done),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign do_grant = pick_valid && !wb_block && !rst;
    assign eng_ack  = do_grant ? pick_grant : '0;

    always_comb begin
        sel_res = '0;
        sel_reg = '0;
        sel_ii  = '0;
        sel_op  = '0;
        sel_idx = '0;
        for (int n = 0; n < N_ENG; n++) begin
            if (pick_grant[n]) begin
                sel_res = eng_res[n*DATA_W +: DATA_W];
                sel_reg = eng_reg[n*REG_W +: REG_W];
                sel_ii  = eng_ii[n*II_W +: II_W];
                sel_op  = eng_op[n*OP_W +: OP_W];
                sel_idx = PW'(n);
            end
        end
    end

    always_comb begin
        rr_ptr_d = do_grant ? sel_idx + PW'(1) : rr_ptr_q;
        out_en_d = do_grant ? ALT_OUTEN : 4'b0000;
        out_ii_d = do_grant ? sel_ii  : '0;
        out_op_d = do_grant ? sel_op  : '0;
        fu_reg_d = do_grant ? sel_reg : '0;
        fu_wen_d = do_grant;

        // The pipe never stalls: wb_block only suppresses new entries
        pipe_vld_d    = '0;
        pipe_vld_d[0] = do_grant;
        pipe_dat_d[0] = do_grant ? sel_res : '0;
        for (int i = 1; i < DATA_DLY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end

        alt_vld_d  = pipe_vld_q[DATA_DLY-1];
        alt_data_d = pipe_vld_q[DATA_DLY-1] ? pipe_dat_q[DATA_DLY-1] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            out_en_q   <= '0;
            out_ii_q   <= '0;
            out_op_q   <= '0;
            fu_reg_q   <= '0;
            fu_wen_q   <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < DATA_DLY; i++) begin
                pipe_dat_q[i] <= '0;
            end
            alt_vld_q  <= 1'b0;
            alt_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            out_en_q   <= out_en_d;
            out_ii_q   <= out_ii_d;
            out_op_q   <= out_op_d;
            fu_reg_q   <= fu_reg_d;
            fu_wen_q   <= fu_wen_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < DATA_DLY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
            alt_vld_q  <= alt_vld_d;
            alt_data_q <= alt_data_d;
        end
    end

    assign outEn      = out_en_q;
    assign outII      = out_ii_q;
    assign outOp      = out_op_q;
    assign FUreg      = fu_reg_q;
    assign FUwen      = fu_wen_q;
    assign outAltData = alt_data_q;
    assign busy       = !rst && (|eng_done || |pipe_vld_q || alt_vld_q);

endmodule
